// File: rtl/pkt_snap_trunc_pkg.sv
// Shared definitions for the snap-length truncator: FSM encodings, length-field bounds, counter width.
// eff_sl() turns the raw snap register into the snap length actually applied to a packet.
package pkt_snap_trunc_pkg;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam int LEN_LO = 0;
  localparam int LEN_HI = 15;
  localparam int LEN_W  = LEN_HI - LEN_LO + 1;
  localparam int CNT_W  = 32;

  localparam logic [LEN_W-1:0] SL_MIN = 16'd64;

  // Zero disables truncation; tiny snap lengths are raised to SL_MIN so a header always survives.
  function automatic logic [LEN_W-1:0] eff_sl(input logic [LEN_W-1:0] raw);
    if (raw == '0) return '0;
    if (raw < SL_MIN) return SL_MIN;
    return raw;
  endfunction

endpackage

// File: rtl/pkt_snap_trunc_fifo.sv
// Small first-word-fallthrough FIFO: head entry is visible on o_dout as soon as o_empty drops.
// Written entry visible the next cycle; o_nearly_full asserts with one free slot left.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_nearly_full,
  output logic             o_empty
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] ONE_LVL  = (MAX_DEPTH_BITS + 1)'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] ONE_PTR = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_depth;
  logic                      w_wr;
  logic                      w_rd;

  assign o_empty       = (r_depth == '0);
  assign o_full        = (r_depth == FULL_LVL);
  assign o_nearly_full = (r_depth >= FULL_LVL - ONE_LVL);
  assign o_dout        = r_mem[r_rd_ptr];
  assign w_wr          = i_wr_en && !o_full;
  assign w_rd          = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_depth  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ONE_PTR;
      if (w_rd) r_rd_ptr <= r_rd_ptr + ONE_PTR;
      case ({w_wr, w_rd})
        2'b10:   r_depth <= r_depth + ONE_LVL;
        2'b01:   r_depth <= r_depth - ONE_LVL;
        default: r_depth <= r_depth;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/pkt_snap_trunc.sv
// Cuts each AXI-Stream packet to the snap length, fixes tlast/tstrb/length, counts packets and cuts.
// One-cycle fallthrough latency; s_axis stalls on FIFO nearly-full, m_axis stalls hold the head beat.
module pkt_snap_trunc
  import pkt_snap_trunc_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int NUM_RW_REGS          = 1,
  parameter int NUM_RO_REGS          = 2
) (
  input  logic                                         axi_aclk,
  input  logic                                         axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]             s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
  input  logic                                         s_axis_tvalid,
  input  logic                                         s_axis_tlast,
  output logic                                         s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]             m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  input  logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]    rw_regs,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]    rw_defaults,
  output logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]    ro_regs
);
  localparam int DW    = C_M_AXIS_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int TW    = C_M_AXIS_TUSER_WIDTH;
  localparam int FW    = DW + BYTES + TW + 1;

  function automatic logic [BYTES-1:0] strb_mask(input logic [LEN_W-1:0] sl);
    logic [LEN_W-1:0] rem;
    rem = sl % LEN_W'(BYTES);
    if (rem == '0) return '1;
    return (BYTES'(1) << rem) - BYTES'(1);
  endfunction

  state_t             r_state, w_next;
  logic [LEN_W-1:0]   r_cnt, r_k;
  logic               r_trunc;
  logic [BYTES-1:0]   r_mask;
  logic [CNT_W-1:0]   r_pkt_cnt, r_trunc_cnt;

  logic [FW-1:0]      w_fifo_dout;
  logic               w_fifo_full, w_fifo_nfull, w_empty, w_rd_en, w_pop_out;
  logic [DW-1:0]      w_h_data;
  logic [BYTES-1:0]   w_h_strb;
  logic [TW-1:0]      w_h_user;
  logic               w_h_last;
  logic [LEN_W-1:0]   w_sl, w_k_new, w_k, w_idx;
  logic [BYTES-1:0]   w_mask_new, w_mask;
  logic               w_trunc_new, w_trunc, w_cut;
  logic               w_unused;

  fallthrough_small_fifo #(
    .WIDTH          (FW),
    .MAX_DEPTH_BITS (2)
  ) u_fifo (
    .i_clk         (axi_aclk),
    .i_rst_n       (axi_aresetn),
    .i_din         ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
    .i_wr_en       (s_axis_tvalid),
    .i_rd_en       (w_rd_en),
    .o_dout        (w_fifo_dout),
    .o_full        (w_fifo_full),
    .o_nearly_full (w_fifo_nfull),
    .o_empty       (w_empty)
  );

  assign s_axis_tready = !w_fifo_nfull;
  assign {w_h_last, w_h_user, w_h_strb, w_h_data} = w_fifo_dout;

  // Snap decision for the head beat; only consumed while in FIRST, then frozen for the packet.
  assign w_sl        = eff_sl(rw_regs[LEN_HI:LEN_LO]);
  assign w_trunc_new = (w_sl != '0) && (w_h_user[LEN_HI:LEN_LO] > w_sl);
  assign w_k_new     = (w_sl - LEN_W'(1)) / LEN_W'(BYTES);
  assign w_mask_new  = strb_mask(w_sl);

  assign w_trunc = (r_state == ST_FIRST) ? w_trunc_new : r_trunc;
  assign w_k     = (r_state == ST_FIRST) ? w_k_new     : r_k;
  assign w_mask  = (r_state == ST_FIRST) ? w_mask_new  : r_mask;
  assign w_idx   = (r_state == ST_FIRST) ? '0          : r_cnt;
  assign w_cut   = w_trunc && (w_idx == w_k);

  assign rw_defaults = '0;
  assign ro_regs     = {r_trunc_cnt, r_pkt_cnt};
  assign w_unused    = ^{w_fifo_full, rw_regs[$bits(rw_regs)-1:LEN_HI+1]};

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) r_state <= ST_FIRST;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FIRST: if (w_rd_en) w_next = w_h_last ? ST_FIRST : (w_cut ? ST_DROP : ST_PASS);
      ST_PASS:  if (w_rd_en) begin
                  if (w_cut)         w_next = w_h_last ? ST_FIRST : ST_DROP;
                  else if (w_h_last) w_next = ST_FIRST;
                end
      ST_DROP:  if (w_rd_en && w_h_last) w_next = ST_FIRST;
      default:  w_next = ST_FIRST;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (r_state != ST_DROP) && !w_empty;
    m_axis_tdata  = w_h_data;
    m_axis_tstrb  = w_cut ? (w_h_strb & w_mask) : w_h_strb;
    m_axis_tuser  = w_h_user;
    if ((r_state == ST_FIRST) && w_trunc) m_axis_tuser[LEN_HI:LEN_LO] = w_sl;
    m_axis_tlast  = w_h_last || w_cut;
    w_pop_out     = m_axis_tvalid && m_axis_tready;
    // DROP drains the remainder of a cut packet without waiting on the downstream.
    w_rd_en       = (r_state == ST_DROP) ? !w_empty : w_pop_out;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_cnt       <= '0;
      r_k         <= '0;
      r_trunc     <= 1'b0;
      r_mask      <= '0;
      r_pkt_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_rd_en && (r_state == ST_FIRST)) begin
        r_cnt   <= LEN_W'(1);
        r_k     <= w_k_new;
        r_trunc <= w_trunc_new;
        r_mask  <= w_mask_new;
      end else if (w_rd_en && (r_state == ST_PASS)) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (w_pop_out && m_axis_tlast) r_pkt_cnt   <= r_pkt_cnt + CNT_W'(1);
      if (w_pop_out && w_cut)        r_trunc_cnt <= r_trunc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pkt_snap_trunc.sv
// Scoreboard bench for pkt_snap_trunc: expected beats queued as packets are driven, checked on output.
`timescale 1ns/1ps
module tb_pkt_snap_trunc;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int TW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [TW-1:0] u;
    logic          l;
  } beat_t;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tstrb = '0;
  logic [TW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [TW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   rw_regs = '0;
  logic [31:0]   rw_defaults;
  logic [63:0]   ro_regs;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mon_beats = 0;
  logic [SW-1:0] mon_last_strb = '0;
  logic [15:0] mon_first_len = '0;
  logic        mon_first = 1'b1;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat;
  logic        rand_en = 1'b0;
  int          b0;

  pkt_snap_trunc dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .rw_regs       (rw_regs),
    .rw_defaults   (rw_defaults),
    .ro_regs       (ro_regs)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge axi_aclk) begin
    #1;
    m_axis_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: pops the scoreboard on each transfer and checks stall stability.
  always @(negedge axi_aclk) begin
    beat_t ob;
    beat_t e;
    ob = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    if (!axi_aresetn) begin
      prev_stall = 1'b0;
      mon_first  = 1'b1;
    end else begin
      if (prev_stall) begin
        chk_eq("stall_vld", 512'(m_axis_tvalid), 512'(1));
        chk_eq("stall_dat", 512'(ob), 512'(prev_beat));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = ob;
      if (m_axis_tvalid && m_axis_tready) begin
        mon_beats++;
        if (mon_first) mon_first_len = ob.u[15:0];
        mon_first     = ob.l;
        mon_last_strb = ob.s;
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_beat", 512'(1), 512'(0));
        end else begin
          e = exp_q.pop_front();
          chk_eq("tdata", 512'(ob.d), 512'(e.d));
          chk_eq("tstrb", 512'(ob.s), 512'(e.s));
          chk_eq("tuser", 512'(ob.u), 512'(e.u));
          chk_eq("tlast", 512'(ob.l), 512'(e.l));
        end
      end
    end
  end

  task automatic drive_beat(input beat_t b);
    int n = 0;
    {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast} = b;
    s_axis_tvalid = 1'b1;
    @(negedge axi_aclk);
    while (!s_axis_tready && n < 500) begin
      n++;
      @(negedge axi_aclk);
    end
    if (!s_axis_tready) chk_eq("in_accept_timeout", 512'(0), 512'(1));
    @(posedge axi_aclk);
    #1;
  endtask

  // Drives the first nstop beats of a len-byte packet, queuing what the output should be.
  task automatic send_pkt(input int len, input int sl_raw, input int nstop);
    beat_t b, e;
    int eff, nin, nout, rem;
    logic tr;
    eff  = (sl_raw == 0) ? 0 : ((sl_raw < 64) ? 64 : sl_raw);
    tr   = (eff != 0) && (len > eff);
    nin  = (len + 31) / 32;
    nout = tr ? (eff + 31) / 32 : nin;
    for (int i = 0; i < nin && i < nstop; i++) begin
      rem = len - 32 * i;
      b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b.s = (rem >= 32) ? '1 : SW'((64'd1 << rem) - 64'd1);
      b.u = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) b.u[15:0] = 16'(len);
      b.l = (i == nin - 1);
      if (i < nout) begin
        e = b;
        if (tr && i == 0) e.u[15:0] = 16'(eff);
        if (tr && i == nout - 1) begin
          e.l = 1'b1;
          if (eff % 32 != 0) e.s = b.s & SW'((64'd1 << (eff % 32)) - 64'd1);
        end
        exp_q.push_back(e);
      end
      drive_beat(b);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      n++;
      @(negedge axi_aclk);
    end
    if (exp_q.size() != 0) chk_eq("drain_timeout", 512'(exp_q.size()), 512'(0));
    repeat (6) @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk_eq("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk_eq("rst_s_tready", 512'(s_axis_tready), 512'(1));
    chk_eq("rst_ro_regs", 512'(ro_regs), 512'(0));
    chk_eq("rw_defaults", 512'(rw_defaults), 512'(0));
    @(posedge axi_aclk);
    #1;

    // No truncation: full 300-byte packet bit-exact.
    rw_regs = 32'h0000_0000;
    b0 = mon_beats;
    send_pkt(300, 0, 99);
    wait_drain();
    chk_eq("t1_beats", 512'(mon_beats - b0), 512'(10));
    chk_eq("t1_len", 512'(mon_first_len), 512'(300));
    chk_eq("t1_ro", 512'(ro_regs), 512'({32'd0, 32'd1}));

    // Snap 100 (upper register bits ignored): 4 beats, partial strobe on the cut beat.
    rw_regs = 32'hABCD_0064;
    b0 = mon_beats;
    send_pkt(300, 100, 99);
    wait_drain();
    chk_eq("t2_beats", 512'(mon_beats - b0), 512'(4));
    chk_eq("t2_strb", 512'(mon_last_strb), 512'(32'h0000_000F));
    chk_eq("t2_len", 512'(mon_first_len), 512'(100));
    chk_eq("t2_drained_vld", 512'(m_axis_tvalid), 512'(0));
    chk_eq("t2_drained_rdy", 512'(s_axis_tready), 512'(1));
    chk_eq("t2_ro", 512'(ro_regs), 512'({32'd1, 32'd2}));

    // Snap 20 clamps to 64.
    rw_regs = 32'd20;
    b0 = mon_beats;
    send_pkt(128, 20, 99);
    wait_drain();
    chk_eq("t3_beats", 512'(mon_beats - b0), 512'(2));
    chk_eq("t3_strb", 512'(mon_last_strb), 512'(32'hFFFF_FFFF));
    chk_eq("t3_len", 512'(mon_first_len), 512'(64));
    chk_eq("t3_ro", 512'(ro_regs), 512'({32'd2, 32'd3}));

    // Snap 96 with random downstream stalls; register cleared once the packet has started.
    rw_regs = 32'd96;
    rand_en = 1'b1;
    b0 = mon_beats;
    fork
      send_pkt(300, 96, 99);
      begin
        int n;
        n = 0;
        while (mon_beats == b0 && n < 2000) begin
          @(posedge axi_aclk);
          n++;
        end
        #1 rw_regs = 32'd0;
      end
    join
    wait_drain();
    rand_en = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1;
    chk_eq("t4_beats", 512'(mon_beats - b0), 512'(3));
    chk_eq("t4_len", 512'(mon_first_len), 512'(96));
    chk_eq("t4_ro", 512'(ro_regs), 512'({32'd3, 32'd4}));

    // Reset in the middle of a packet, then a fresh 64-byte packet.
    rw_regs = 32'd200;
    send_pkt(300, 200, 5);
    @(posedge axi_aclk);
    #1 axi_aresetn = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk_eq("t5_rst_vld", 512'(m_axis_tvalid), 512'(0));
    chk_eq("t5_rst_ro", 512'(ro_regs), 512'(0));
    chk_eq("t5_rst_q", 512'(exp_q.size()), 512'(0));
    @(posedge axi_aclk);
    #1;
    b0 = mon_beats;
    send_pkt(64, 200, 99);
    wait_drain();
    chk_eq("t5_beats", 512'(mon_beats - b0), 512'(2));
    chk_eq("t5_len", 512'(mon_first_len), 512'(64));
    chk_eq("t5_ro", 512'(ro_regs), 512'({32'd0, 32'd1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
